// File: rtl/firebird7_in_gate1_tdr_pkg.sv
// Shared definitions for the firebird7_in_gate1 IJTAG test data registers.
// The operation decode lives here so every sibling TDR resolves its
// enables with the same priority.
package firebird7_in_gate1_tdr_pkg;

  // Data field width of the 19-bit gated data path, and its scan length
  // (one extra bit for the select).
  localparam int TDR_W19_DATA_WIDTH = 19;
  localparam int TDR_W19_SCAN_LEN   = TDR_W19_DATA_WIDTH + 1;

  typedef enum logic [1:0] {
    TDR_HOLD    = 2'd0,
    TDR_SHIFT   = 2'd1,
    TDR_CAPTURE = 2'd2,
    TDR_UPDATE  = 2'd3
  } tdr_op_e;

  // Fixed priority SHIFT > CAPTURE > UPDATE; nothing happens unless selected.
  function automatic tdr_op_e tdr_decode(input logic sel, input logic se,
                                         input logic ce, input logic ue);
    tdr_op_e op;
    op = TDR_HOLD;
    if (sel) begin
      if (se)      op = TDR_SHIFT;
      else if (ce) op = TDR_CAPTURE;
      else if (ue) op = TDR_UPDATE;
    end
    return op;
  endfunction

endpackage

// File: rtl/firebird7_in_gate1_tessent_tdr_w19_sel.sv
// IJTAG TDR feeding the 19-bit functional/IJTAG data mux: the update stage
// drives the mux data and select, capture observes the mux output.
module firebird7_in_gate1_tessent_tdr_w19_sel
  import firebird7_in_gate1_tdr_pkg::*;
#(
  parameter int                    DATA_WIDTH = TDR_W19_DATA_WIDTH,
  parameter logic [DATA_WIDTH-1:0] RESET_DATA = '0,
  parameter bit                    CAPTURE_EN = 1'b1
) (
  input  logic                  ijtag_tck,
  input  logic                  ijtag_reset,
  input  logic                  ijtag_sel,
  input  logic                  ijtag_se,
  input  logic                  ijtag_ce,
  input  logic                  ijtag_ue,
  input  logic                  ijtag_si,
  output logic                  ijtag_so,
  input  logic [DATA_WIDTH-1:0] capture_data_in,
  output logic [DATA_WIDTH-1:0] ijtag_data_out,
  output logic                  ijtag_select
);

  localparam int SCAN_LEN = DATA_WIDTH + 1;

  logic [SCAN_LEN-1:0] sr_q, sr_d;
  logic [SCAN_LEN-1:0] upd_q, upd_d;
  logic [SCAN_LEN-1:0] cap_val;
  tdr_op_e             op;

  // Capture source: observed mux data with the live select bit, or a plain
  // readback of the update stage when observation is not wanted.
  generate
    if (CAPTURE_EN) begin : g_cap_obs
      assign cap_val = {upd_q[DATA_WIDTH], capture_data_in};
    end else begin : g_cap_readback
      assign cap_val = upd_q;
    end
  endgenerate

  assign op = tdr_decode(ijtag_sel, ijtag_se, ijtag_ce, ijtag_ue);

  // Next-state selection: only the single decoded operation touches state.
  always_comb begin
    sr_d  = sr_q;
    upd_d = upd_q;
    case (op)
      TDR_SHIFT:   sr_d  = {ijtag_si, sr_q[SCAN_LEN-1:1]};
      TDR_CAPTURE: sr_d  = cap_val;
      TDR_UPDATE:  upd_d = sr_q;
      default:     ;
    endcase
  end

  // Shift and update stages; reset clears immediately without a clock.
  always_ff @(posedge ijtag_tck or negedge ijtag_reset) begin
    if (!ijtag_reset) begin
      sr_q  <= '0;
      upd_q <= {1'b0, RESET_DATA};
    end else begin
      sr_q  <= sr_d;
      upd_q <= upd_d;
    end
  end

  // Outputs come straight from flops so the mux never sees a glitch.
  assign ijtag_so       = sr_q[0];
  assign ijtag_select   = upd_q[DATA_WIDTH];
  assign ijtag_data_out = upd_q[DATA_WIDTH-1:0];

endmodule
